// File: rtl/traceback_engine_pkg.sv
// Shared encodings for the traceback engine: CIGAR op codes, direction-field
// layout, trace states and FSM states.
package traceback_engine_pkg;

  localparam int DIR_WIDTH     = 5;
  localparam int PES_PER_WORD  = 16;
  localparam int WORD_WIDTH    = DIR_WIDTH * PES_PER_WORD;
  localparam int SRC_MSB       = 2;
  localparam int EXT_SHORT_BIT = 3;
  localparam int EXT_LONG_BIT  = 4;

  localparam logic [1:0] OP_M = 2'd0;
  localparam logic [1:0] OP_I = 2'd1;
  localparam logic [1:0] OP_D = 2'd2;

  localparam logic [2:0] SRC_STOP = 3'd0;
  localparam logic [2:0] SRC_DIAG = 3'd1;
  localparam logic [2:0] SRC_E1   = 3'd2;
  localparam logic [2:0] SRC_E2   = 3'd3;
  localparam logic [2:0] SRC_F1   = 3'd4;
  localparam logic [2:0] SRC_F2   = 3'd5;

  typedef enum logic [2:0] {TR_H, TR_E1, TR_E2, TR_F1, TR_F2} trace_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_DECODE, ST_EMIT, ST_FLUSH, ST_FIN
  } state_t;

endpackage

// File: rtl/traceback_engine_dir_field_extract.sv
// Picks one cell's direction field out of an 80-bit SRAM word; local row 0
// sits in the top slice, mirroring how the array packs its 16 PEs.
module dir_field_extract
  import traceback_engine_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] i_word,
  input  logic [3:0]            i_row,
  output logic [DIR_WIDTH-1:0]  o_field
);

  always_comb begin
    o_field = '0;
    for (int i = 0; i < PES_PER_WORD; i++) begin
      if (i_row == 4'(PES_PER_WORD - 1 - i)) o_field = i_word[i*DIR_WIDTH +: DIR_WIDTH];
    end
  end

endmodule

// File: rtl/traceback_engine.sv
// Walks the affine-gap direction matrix back from the traceback cell and
// emits run-length CIGAR operations over a valid/ready handshake.
module traceback_engine
  import traceback_engine_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 10,
  parameter int MEM_BLOCK_WIDTH = 4,
  parameter int LEN_WIDTH       = 11
)(
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       start,
  input  logic [ADDRESS_WIDTH-1:0]   tb_x_i,
  input  logic [ADDRESS_WIDTH-1:0]   tb_y_i,
  input  logic                       bank_i,
  output logic                       use_s1,
  output logic [MEM_BLOCK_WIDTH-1:0] mem_block_num,
  output logic [ADDRESS_WIDTH-1:0]   column_num,
  input  logic [WORD_WIDTH-1:0]      column_k0,
  output logic                       busy,
  output logic                       op_valid,
  input  logic                       op_ready,
  output logic [1:0]                 op_code,
  output logic [LEN_WIDTH-1:0]       op_len,
  output logic                       done,
  output logic [ADDRESS_WIDTH-1:0]   start_x,
  output logic [ADDRESS_WIDTH-1:0]   start_y
);

  state_t                     r_state, w_next_state;
  trace_t                     r_tstate, w_next_t;
  logic [ADDRESS_WIDTH-1:0]   r_x, r_y, w_nx, w_ny, w_ym1;
  logic [DIR_WIDTH-1:0]       r_dir, w_field;
  logic [1:0]                 r_cur_op, r_pend_op, w_step_op;
  logic [LEN_WIDTH-1:0]       r_cur_len;
  logic                       r_term, r_use_s1;
  logic                       w_step, w_gap_open, w_stop, w_ext, w_term, w_new_run;
  logic [2:0]                 w_src;

  // Row 0 never addresses the SRAM; clamp so idle/reset addresses read as 0.
  assign w_ym1         = (r_y == '0) ? '0 : r_y - ADDRESS_WIDTH'(1);
  assign mem_block_num = MEM_BLOCK_WIDTH'(w_ym1 >> 4);
  assign column_num    = r_x;
  assign use_s1        = r_use_s1;
  assign op_code       = r_cur_op;
  assign op_len        = r_cur_len;

  dir_field_extract u_extract (
    .i_word  (column_k0),
    .i_row   (4'(w_ym1)),
    .o_field (w_field)
  );

  assign w_src = r_dir[SRC_MSB:0];

  always_comb begin
    w_step     = 1'b0;
    w_gap_open = 1'b0;
    w_stop     = 1'b0;
    w_ext      = 1'b0;
    w_step_op  = OP_M;
    w_nx       = r_x;
    w_ny       = r_y;
    w_next_t   = r_tstate;
    case (r_tstate)
      TR_H: begin
        case (w_src)
          SRC_DIAG: begin
            w_step = 1'b1;
            w_nx   = r_x - ADDRESS_WIDTH'(1);
            w_ny   = r_y - ADDRESS_WIDTH'(1);
          end
          SRC_E1:  begin w_gap_open = 1'b1; w_next_t = TR_E1; end
          SRC_E2:  begin w_gap_open = 1'b1; w_next_t = TR_E2; end
          SRC_F1:  begin w_gap_open = 1'b1; w_next_t = TR_F1; end
          SRC_F2:  begin w_gap_open = 1'b1; w_next_t = TR_F2; end
          default: w_stop = 1'b1;
        endcase
      end
      TR_E1, TR_E2: begin
        w_step    = 1'b1;
        w_step_op = OP_I;
        w_ny      = r_y - ADDRESS_WIDTH'(1);
        w_ext     = (r_tstate == TR_E1) ? r_dir[EXT_SHORT_BIT] : r_dir[EXT_LONG_BIT];
        w_next_t  = w_ext ? r_tstate : TR_H;
      end
      TR_F1, TR_F2: begin
        w_step    = 1'b1;
        w_step_op = OP_D;
        w_nx      = r_x - ADDRESS_WIDTH'(1);
        w_ext     = (r_tstate == TR_F1) ? r_dir[EXT_SHORT_BIT] : r_dir[EXT_LONG_BIT];
        w_next_t  = w_ext ? r_tstate : TR_H;
      end
      default: w_stop = 1'b1;
    endcase
  end

  assign w_term    = w_stop || (w_step && (w_nx == '0 || w_ny == '0));
  assign w_new_run = (r_cur_len != '0) && (w_step_op != r_cur_op);

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = ST_ISSUE;
      ST_ISSUE:  w_next_state = ST_WAIT;
      ST_WAIT:   w_next_state = ST_DECODE;
      ST_DECODE: begin
        if (w_stop)          w_next_state = ST_FLUSH;
        else if (w_gap_open) w_next_state = ST_DECODE;
        else if (w_new_run)  w_next_state = ST_EMIT;
        else if (w_term)     w_next_state = ST_FLUSH;
        else                 w_next_state = ST_ISSUE;
      end
      ST_EMIT:   if (op_ready) w_next_state = r_term ? ST_FLUSH : ST_ISSUE;
      ST_FLUSH:  if (r_cur_len == '0 || op_ready) w_next_state = ST_FIN;
      ST_FIN:    w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE) && (r_state != ST_FIN);
    op_valid = (r_state == ST_EMIT) || ((r_state == ST_FLUSH) && (r_cur_len != '0));
    done     = (r_state == ST_FIN);
  end

  // A run that changes op parks the new op in r_pend_op until the old run drains.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_x       <= '0;
      r_y       <= '0;
      r_tstate  <= TR_H;
      r_dir     <= '0;
      r_cur_op  <= OP_M;
      r_pend_op <= OP_M;
      r_cur_len <= '0;
      r_term    <= 1'b0;
      r_use_s1  <= 1'b0;
      start_x   <= '0;
      start_y   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_x       <= tb_x_i;
          r_y       <= tb_y_i;
          r_use_s1  <= bank_i;
          r_tstate  <= TR_H;
          r_cur_op  <= OP_M;
          r_cur_len <= '0;
          r_term    <= 1'b0;
        end
        ST_WAIT: r_dir <= w_field;
        ST_DECODE: begin
          if (w_stop) begin
            start_x <= r_x;
            start_y <= r_y;
          end else if (w_gap_open) begin
            r_tstate <= w_next_t;
          end else begin
            r_x      <= w_nx;
            r_y      <= w_ny;
            r_tstate <= w_next_t;
            r_term   <= w_term;
            if (w_term) begin
              start_x <= r_x;
              start_y <= r_y;
            end
            if (w_new_run) begin
              r_pend_op <= w_step_op;
            end else if (r_cur_len == '0) begin
              r_cur_op  <= w_step_op;
              r_cur_len <= LEN_WIDTH'(1);
            end else begin
              r_cur_len <= r_cur_len + LEN_WIDTH'(1);
            end
          end
        end
        ST_EMIT: if (op_ready) begin
          r_cur_op  <= r_pend_op;
          r_cur_len <= LEN_WIDTH'(1);
        end
        ST_FLUSH: if (op_ready) r_cur_len <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_engine.sv
// Directed bench for traceback_engine: a small direction-matrix SRAM model,
// a table of traces with hand-derived CIGAR runs, and reset/backpressure sequences.
module tb_traceback_engine;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start;
  logic [9:0]  tb_x_i, tb_y_i;
  logic        bank_i;
  logic        use_s1;
  logic [3:0]  mem_block_num;
  logic [9:0]  column_num;
  logic [79:0] column_k0;
  logic        busy, op_valid, op_ready, done;
  logic [1:0]  op_code;
  logic [10:0] op_len;
  logic [9:0]  start_x, start_y;

  traceback_engine dut (
    .clk(clk), .reset_i(reset_i), .start(start), .tb_x_i(tb_x_i), .tb_y_i(tb_y_i),
    .bank_i(bank_i), .use_s1(use_s1), .mem_block_num(mem_block_num),
    .column_num(column_num), .column_k0(column_k0), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_len(op_len),
    .done(done), .start_x(start_x), .start_y(start_y)
  );

  always #5 clk = ~clk;

  logic [4:0] dm [0:31][0:31];

  function automatic logic [79:0] pack_word(input logic [9:0] cx, input logic [3:0] blk);
    logic [79:0] w;
    int row;
    w = '0;
    for (int l = 0; l < 16; l++) begin
      row = int'(blk) * 16 + l + 1;
      if (cx < 10'd32 && row < 32) w[(15-l)*5 +: 5] = dm[cx[4:0]][row[4:0]];
    end
    return w;
  endfunction

  always @(posedge clk) column_k0 <= pack_word(column_num, mem_block_num);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]        sc;
    logic [9:0]        tx, ty;
    logic              bank, stall, spur;
    logic [1:0]        nrun;
    logic [2:0][1:0]   op;
    logic [2:0][10:0]  len;
    logic [9:0]        sx, sy;
    logic [7:0]        minbusy;
    logic [3:0]        eblk;
  } vec_t;

  function automatic vec_t mk(input int sc, tx, ty, bank, stall, spur, nrun,
                              o0, l0, o1, l1, o2, l2, sx, sy, minb, eblk);
    vec_t v;
    v.sc = 4'(sc); v.tx = 10'(tx); v.ty = 10'(ty);
    v.bank = 1'(bank); v.stall = 1'(stall); v.spur = 1'(spur); v.nrun = 2'(nrun);
    v.op[0] = 2'(o0); v.len[0] = 11'(l0);
    v.op[1] = 2'(o1); v.len[1] = 11'(l1);
    v.op[2] = 2'(o2); v.len[2] = 11'(l2);
    v.sx = 10'(sx); v.sy = 10'(sy); v.minbusy = 8'(minb); v.eblk = 4'(eblk);
    return v;
  endfunction

  task automatic setup(input int sc);
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) dm[i][j] = 5'd0;
    case (sc)
      0: for (int i = 1; i <= 4; i++) dm[i][i] = 5'd1;
      1: begin dm[5][3] = 5'd1; dm[4][2] = 5'd12; dm[3][2] = 5'd16; dm[2][2] = 5'd1; end
      2: begin dm[2][6] = 5'd19; dm[2][5] = 5'd16; dm[2][4] = 5'd16; dm[2][3] = 5'd8;
               dm[2][2] = 5'd1; end
      3: dm[7][9] = 5'd0;
      4: begin dm[2][17] = 5'd1; dm[1][16] = 5'd1; end
      5: begin dm[3][2] = 5'd18; dm[3][1] = 5'd1; end
      6: dm[3][3] = 5'd6;
      7: dm[12][20] = 5'd7;
      default: ;
    endcase
  endtask

  logic [1:0]  got_op  [0:7];
  logic [10:0] got_len [0:7];
  int          got_n, busy_cyc;
  logic [9:0]  got_sx, got_sy, got_col0;
  logic [3:0]  got_blk0;
  logic        done_seen, stall_bad;

  task automatic run_vec(input vec_t v);
    int         stall_left;
    logic       stalled_once;
    logic [1:0] h_op;
    logic [10:0] h_len;
    logic [9:0] h_col;
    logic [3:0] h_blk;
    got_n = 0; busy_cyc = 0; done_seen = 0; stall_bad = 0;
    stall_left = 0; stalled_once = 0;
    h_op = '0; h_len = '0; h_col = '0; h_blk = '0;
    @(negedge clk);
    tb_x_i = v.tx; tb_y_i = v.ty; bank_i = v.bank; start = 1'b1; op_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_blk0 = mem_block_num; got_col0 = column_num;
    chk("use_s1", int'(use_s1), int'(v.bank));
    chk("busy_start", int'(busy), 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (v.spur && cyc == 4) begin start = 1'b1; tb_x_i = 10'd7; tb_y_i = 10'd9; end
      else start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        got_sx = start_x; got_sy = start_y; done_seen = 1'b1;
        break;
      end
      if (op_valid) begin
        if (v.stall && !stalled_once) begin
          stalled_once = 1'b1; stall_left = 10;
          h_op = op_code; h_len = op_len; h_col = column_num; h_blk = mem_block_num;
        end
        if (stall_left > 0) begin
          op_ready = 1'b0;
          if (op_code != h_op || op_len != h_len || column_num != h_col ||
              mem_block_num != h_blk) stall_bad = 1'b1;
          stall_left--;
        end else begin
          op_ready = 1'b1;
          if (got_n < 8) begin got_op[got_n] = op_code; got_len[got_n] = op_len; end
          got_n++;
        end
      end else begin
        op_ready = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", int'(done_seen), 1);
    if (done_seen) begin
      @(negedge clk);
      chk("done_pulse", int'(done), 0);
      chk("busy_after", int'(busy), 0);
    end else begin
      reset_i = 1'b0;
      @(negedge clk);
      reset_i = 1'b1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    reset_i = 1'b0; start = 1'b0; op_ready = 1'b1; bank_i = 1'b0;
    tb_x_i = '0; tb_y_i = '0;
    setup(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_use_s1", int'(use_s1), 0);
    chk("rst_blk", int'(mem_block_num), 0);
    chk("rst_col", int'(column_num), 0);
    chk("rst_sx", int'(start_x), 0);
    chk("rst_sy", int'(start_y), 0);
    chk("rst_len", int'(op_len), 0);
    reset_i = 1'b1;

    //             sc tx  ty bk st sp n  o0 l0 o1 l1 o2 l2 sx  sy mb  blk
    vecs.push_back(mk(0, 4,  4, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 1,  1, 12, 0));
    vecs.push_back(mk(1, 5,  3, 1, 0, 0, 3, 0, 1, 2, 2, 0, 1, 1,  1, 0,  0));
    vecs.push_back(mk(2, 2,  6, 0, 0, 0, 2, 1, 4, 0, 1, 0, 0, 1,  1, 0,  0));
    vecs.push_back(mk(3, 7,  9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7,  9, 0,  0));
    vecs.push_back(mk(4, 2, 17, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 16, 0,  1));
    vecs.push_back(mk(5, 3,  2, 0, 0, 0, 2, 1, 1, 0, 1, 0, 0, 3,  1, 0,  0));
    vecs.push_back(mk(1, 5,  3, 0, 1, 0, 3, 0, 1, 2, 2, 0, 1, 1,  1, 0,  0));
    vecs.push_back(mk(0, 4,  4, 1, 0, 1, 1, 0, 4, 0, 0, 0, 0, 1,  1, 12, 0));
    vecs.push_back(mk(6, 3,  3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3,  3, 0,  0));
    vecs.push_back(mk(7, 12, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 20, 0, 1));

    foreach (vecs[k]) begin
      setup(int'(vecs[k].sc));
      run_vec(vecs[k]);
      chk($sformatf("v%0d_blk0", k), int'(got_blk0), int'(vecs[k].eblk));
      chk($sformatf("v%0d_col0", k), int'(got_col0), int'(vecs[k].tx));
      chk($sformatf("v%0d_nruns", k), got_n, int'(vecs[k].nrun));
      for (int i = 0; i < int'(vecs[k].nrun); i++) begin
        if (i < got_n) begin
          chk($sformatf("v%0d_op%0d", k, i), int'(got_op[i]), int'(vecs[k].op[i]));
          chk($sformatf("v%0d_len%0d", k, i), int'(got_len[i]), int'(vecs[k].len[i]));
        end
      end
      if (done_seen) begin
        chk($sformatf("v%0d_start_x", k), int'(got_sx), int'(vecs[k].sx));
        chk($sformatf("v%0d_start_y", k), int'(got_sy), int'(vecs[k].sy));
      end
      if (vecs[k].minbusy != 0)
        chk($sformatf("v%0d_busy_cycles_ok", k), int'(busy_cyc >= int'(vecs[k].minbusy)), 1);
      if (vecs[k].stall)
        chk($sformatf("v%0d_stall_stable", k), int'(stall_bad), 0);
    end

    // Asynchronous reset while a run is being presented.
    setup(1);
    @(negedge clk);
    tb_x_i = 10'd5; tb_y_i = 10'd3; bank_i = 1'b1; start = 1'b1; op_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (op_valid) break;
      @(negedge clk);
    end
    chk("mid_valid_reached", int'(op_valid), 1);
    #2 reset_i = 1'b0;
    #1;
    chk("mid_rst_valid", int'(op_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_use_s1", int'(use_s1), 0);
    chk("mid_rst_len", int'(op_len), 0);
    @(negedge clk);
    reset_i = 1'b1;
    op_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_done", int'(done), 0);
    end
    chk("post_rst_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
